// File: rtl/video_pkg.sv
// video_pkg: 640x480@60 timing defaults, derived boundaries and an 11-bit span helper.
package video_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int PIPE_DLY_DEF = 1;
  // Boundaries are summed at 11 bits so a full 800-clock line never overflows.
  function automatic logic [10:0] span(input int a, input int b, input int c, input int d);
    return 11'(a) + 11'(b) + 11'(c) + 11'(d);
  endfunction
  localparam logic [10:0] H_TOTAL      = span(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam logic [10:0] V_TOTAL      = span(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam logic [10:0] H_SYNC_START = span(H_ACTIVE_DEF, H_FP_DEF, 0, 0);
  localparam logic [10:0] H_SYNC_END   = span(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, 0);
  localparam logic [10:0] V_SYNC_START = span(V_ACTIVE_DEF, V_FP_DEF, 0, 0);
  localparam logic [10:0] V_SYNC_END   = span(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, 0);
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: renderer colour in, counts/syncs/gated colour out.
interface video_timing_gen_if;
  logic [7:0] Red_in, Green_in, Blue_in;
  logic [9:0] Hcount;
  logic [8:0] Vcount;
  logic       FrameStart, Hsync, Vsync, Active;
  logic [7:0] Red, Green, Blue;
  modport master (
    input  Red_in, Green_in, Blue_in,
    output Hcount, Vcount, FrameStart, Hsync, Vsync, Active, Red, Green, Blue
  );
  modport slave (
    output Red_in, Green_in, Blue_in,
    input  Hcount, Vcount, FrameStart, Hsync, Vsync, Active, Red, Green, Blue
  );
endinterface

// File: rtl/delay_line.sv
// delay_line: DEPTH-stage register shift with reset value RST_VAL; DEPTH 0 is a wire.
module delay_line #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_reg
    logic [WIDTH-1:0] stg [DEPTH];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end
    assign q = stg[DEPTH-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel/line counters with sync, visible flag and colour aligned PIPE_DLY+1 clocks behind.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIPE_DLY = PIPE_DLY_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  video_timing_gen_if.master  vif
);
  localparam logic [10:0] HT  = span(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam logic [10:0] VT  = span(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [10:0] HA  = span(H_ACTIVE, 0, 0, 0);
  localparam logic [10:0] VA  = span(V_ACTIVE, 0, 0, 0);
  localparam logic [10:0] HSS = span(H_ACTIVE, H_FP, 0, 0);
  localparam logic [10:0] HSE = span(H_ACTIVE, H_FP, H_SYNC, 0);
  localparam logic [10:0] VSS = span(V_ACTIVE, V_FP, 0, 0);
  localparam logic [10:0] VSE = span(V_ACTIVE, V_FP, V_SYNC, 0);
  logic [9:0]  h_cnt, v_cnt;
  logic [10:0] h_w, v_w;
  logic        h_end, v_end, hs_raw, vs_raw, vis_raw, hs_d, vs_d, vis_d;
  assign h_w     = {1'b0, h_cnt};
  assign v_w     = {1'b0, v_cnt};
  assign h_end   = h_w == HT - 11'd1;
  assign v_end   = v_w == VT - 11'd1;
  assign hs_raw  = !(h_w >= HSS && h_w < HSE);
  assign vs_raw  = !(v_w >= VSS && v_w < VSE);
  assign vis_raw = h_w < HA && v_w < VA;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 10'd1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 10'd1;
    end
  end
  assign vif.Hcount     = h_cnt;
  assign vif.Vcount     = v_cnt[8:0];
  assign vif.FrameStart = Reset && h_cnt == '0 && v_cnt == '0;
  // Stage reset value keeps syncs high and the picture blank until real timing emerges.
  delay_line #(.WIDTH(3), .DEPTH(PIPE_DLY), .RST_VAL(3'b110)) u_dly (
    .clk   (Clk),
    .reset (Reset),
    .d     ({hs_raw, vs_raw, vis_raw}),
    .q     ({hs_d, vs_d, vis_d})
  );
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vif.Hsync  <= 1'b1;
      vif.Vsync  <= 1'b1;
      vif.Active <= 1'b0;
      vif.Red    <= '0;
      vif.Green  <= '0;
      vif.Blue   <= '0;
    end else begin
      vif.Hsync  <= hs_d;
      vif.Vsync  <= vs_d;
      vif.Active <= vis_d;
      vif.Red    <= vis_d ? vif.Red_in   : '0;
      vif.Green  <= vis_d ? vif.Green_in : '0;
      vif.Blue   <= vis_d ? vif.Blue_in  : '0;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three configurations checked every clock against an arithmetic timing model.
module tb_video_timing_gen;
  typedef struct {int ha, hf, hs, hb, va, vf, vs, vb, d;} cfg_t;
  typedef struct {int h, v, fs, hs, vs, act, r, g, b;} exp_t;
  typedef struct {int n, h, v, fs, hs, act;} vec_t;
  logic clk = 1'b0, reset = 1'b0;
  int checks = 0, errors = 0, n = 0;
  bit in_reset = 1'b1;
  logic [7:0] lut [256];
  cfg_t cfg [3];
  vec_t tbl [12];
  exp_t rst_e;
  int hs_first = -1, hs_low = 0, vs_first = -1, vs_low = 0, fs_second = -1;
  video_timing_gen_if vif0 (), vif1 (), vif2 ();
  video_timing_gen u0 (.Clk(clk), .Reset(reset), .vif(vif0));
  video_timing_gen #(.PIPE_DLY(2)) u1 (.Clk(clk), .Reset(reset), .vif(vif1));
  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(6), .V_FP(2),
                     .V_SYNC(2), .V_BP(2), .PIPE_DLY(0)) u2 (.Clk(clk), .Reset(reset), .vif(vif2));
  always #5 clk = ~clk;

  function automatic logic [23:0] col(input int h, input int v);
    logic [7:0] hr;
    hr = 8'(h);
    return {hr, lut[(h + 7 * v) & 255], lut[(3 * h + v) & 255]};
  endfunction

  // Expected outputs k clocks after reset release: counts now, everything else for the count D+1 clocks ago.
  function automatic exp_t model(input cfg_t c, input int k);
    exp_t e;
    int ht, vt, m, ph, pv;
    logic [23:0] cc;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    e = rst_e;
    e.h = k % ht;
    e.v = (k / ht) % vt;
    e.fs = (e.h == 0 && e.v == 0) ? 1 : 0;
    m = k - c.d - 1;
    if (m >= 0) begin
      ph = m % ht;
      pv = (m / ht) % vt;
      e.hs = (ph >= c.ha + c.hf && ph < c.ha + c.hf + c.hs) ? 0 : 1;
      e.vs = (pv >= c.va + c.vf && pv < c.va + c.vf + c.vs) ? 0 : 1;
      e.act = (ph < c.ha && pv < c.va) ? 1 : 0;
      if (e.act == 1) begin
        cc = col(ph, pv);
        e.r = int'(cc[23:16]);
        e.g = int'(cc[15:8]);
        e.b = int'(cc[7:0]);
      end
    end
    return e;
  endfunction

  // Renderer: supplies the colour of the position presented D clocks earlier.
  function automatic logic [23:0] pix(input int i);
    int k, ht, vt;
    k = n - cfg[i].d;
    if (in_reset || k < 0) return 24'($urandom);
    ht = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    vt = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
    return col(k % ht, (k / ht) % vt);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, reset %0d)", nm, act, exp, n, in_reset);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [9:0] h, input logic [8:0] v,
                     input logic fs, input logic hs, input logic vs, input logic act,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    chk({nm, " Hcount"}, int'(h), e.h);
    chk({nm, " Vcount"}, int'(v), e.v & 511);
    chk({nm, " FrameStart"}, int'(fs), e.fs);
    chk({nm, " Hsync"}, int'(hs), e.hs);
    chk({nm, " Vsync"}, int'(vs), e.vs);
    chk({nm, " Active"}, int'(act), e.act);
    chk({nm, " Red"}, int'(r), e.r);
    chk({nm, " Green"}, int'(g), e.g);
    chk({nm, " Blue"}, int'(b), e.b);
  endtask

  function automatic exp_t expect_for(input int i);
    if (in_reset) return rst_e;
    return model(cfg[i], n);
  endfunction

  task automatic check_all();
    cmp("u0", expect_for(0), vif0.Hcount, vif0.Vcount, vif0.FrameStart, vif0.Hsync, vif0.Vsync,
        vif0.Active, vif0.Red, vif0.Green, vif0.Blue);
    cmp("u1", expect_for(1), vif1.Hcount, vif1.Vcount, vif1.FrameStart, vif1.Hsync, vif1.Vsync,
        vif1.Active, vif1.Red, vif1.Green, vif1.Blue);
    cmp("u2", expect_for(2), vif2.Hcount, vif2.Vcount, vif2.FrameStart, vif2.Hsync, vif2.Vsync,
        vif2.Active, vif2.Red, vif2.Green, vif2.Blue);
  endtask

  task automatic drive_all();
    {vif0.Red_in, vif0.Green_in, vif0.Blue_in} = pix(0);
    {vif1.Red_in, vif1.Green_in, vif1.Blue_in} = pix(1);
    {vif2.Red_in, vif2.Green_in, vif2.Blue_in} = pix(2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    in_reset = !reset;
    if (!in_reset) n++;
    check_all();
    drive_all();
  endtask

  task automatic hold_reset(input int cyc);
    reset = 1'b0;
    repeat (cyc) tick();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    in_reset = 1'b0;
    n = 0;
    #1;
    check_all();
    drive_all();
  endtask

  task automatic run(input int cyc);
    repeat (cyc) tick();
  endtask

  task automatic track();
    if (n < 800 && vif0.Hsync == 1'b0) begin
      if (hs_first < 0) hs_first = n;
      hs_low++;
    end
    if (n < 288 && vif2.Vsync == 1'b0) begin
      if (vs_first < 0) vs_first = n;
      vs_low++;
    end
    if (n > 0 && vif2.FrameStart && fs_second < 0) fs_second = n;
    if (n == 8) begin
      chk("u1 red at h5", int'(vif1.Red), 5);
      chk("u1 active at h5", int'(vif1.Active), 1);
    end
    if (n == 643) begin
      chk("u1 red at h640", int'(vif1.Red), 0);
      chk("u1 active at h640", int'(vif1.Active), 0);
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    cfg[2] = '{16, 2, 3, 3, 6, 2, 2, 2, 0};
    rst_e = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    foreach (lut[i]) lut[i] = 8'($urandom);
    // {cycle after release, Hcount, Vcount, FrameStart, Hsync, Active} for the default PIPE_DLY=1 unit
    tbl = '{'{0, 0, 0, 1, 1, 0}, '{1, 1, 0, 0, 1, 0}, '{2, 2, 0, 0, 1, 1},
            '{641, 641, 0, 0, 1, 1}, '{642, 642, 0, 0, 1, 0}, '{657, 657, 0, 0, 1, 0},
            '{658, 658, 0, 0, 0, 0}, '{753, 753, 0, 0, 0, 0}, '{754, 754, 0, 0, 1, 0},
            '{799, 799, 0, 0, 1, 0}, '{800, 0, 1, 0, 1, 0}, '{802, 2, 1, 0, 1, 1}};
    drive_all();
    hold_reset(5);
    release_reset();
    track();
    foreach (tbl[k]) begin
      while (n < tbl[k].n) begin
        tick();
        track();
      end
      chk($sformatf("tbl[%0d] Hcount", k), int'(vif0.Hcount), tbl[k].h);
      chk($sformatf("tbl[%0d] Vcount", k), int'(vif0.Vcount), tbl[k].v);
      chk($sformatf("tbl[%0d] FrameStart", k), int'(vif0.FrameStart), tbl[k].fs);
      chk($sformatf("tbl[%0d] Hsync", k), int'(vif0.Hsync), tbl[k].hs);
      chk($sformatf("tbl[%0d] Active", k), int'(vif0.Active), tbl[k].act);
    end
    while (n < 2300) begin
      tick();
      track();
    end
    chk("u0 hsync first low", hs_first, 658);
    chk("u0 hsync low width", hs_low, 96);
    chk("u2 vsync first low", vs_first, 193);
    chk("u2 vsync low width", vs_low, 48);
    chk("u2 frame period", fs_second, 288);
    // Abort in the middle of a horizontal sync pulse: it must not resume after release.
    chk("u0 hsync low before abort", int'(vif0.Hsync), 0);
    hold_reset(1);
    chk("u0 hsync after abort", int'(vif0.Hsync), 1);
    release_reset();
    chk("u0 framestart after abort", int'(vif0.FrameStart), 1);
    run($urandom_range(300, 1500));
    hold_reset($urandom_range(1, 4));
    release_reset();
    run(900);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, meaning horizontal front porch (clocks).
REQ-003 SHALL have parameter H_SYNC, default 96, meaning horizontal sync width (clocks).
REQ-004 SHALL have parameter H_BP, default 48, meaning horizontal back porch (clocks); line total is 800.
REQ-005 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, meaning vertical front porch (lines).
REQ-007 SHALL have parameter V_SYNC, default 2, meaning vertical sync width (lines).
REQ-008 SHALL have parameter V_BP, default 33, meaning vertical back porch (lines); frame total is 525.
REQ-009 SHALL have parameter PIPE_DLY, default 1, range 0..3, meaning the number of clocks between a count being presented and Red_in/Green_in/Blue_in for that pixel being valid.
REQ-010 Clk  in  1  pixel clock, 25 MHz.
REQ-011 Reset  in  1  synchronous, active-low reset.
REQ-012 Red_in / Green_in / Blue_in  in  8 each  pixel colour from the renderer.
REQ-013 Hcount  out  10  current horizontal position, 0..799.
REQ-014 Vcount  out  9  current vertical position, low 9 bits of 0..524.
REQ-015 FrameStart  out  1  one-clock pulse at position (0,0).
REQ-016 Hsync / Vsync  out  1 each  active-low sync to the connector.
REQ-017 Active  out  1  pixel-aligned visible-area flag.
REQ-018 Red / Green / Blue  out  8 each  pixel colour to the connector.

Function
REQ-019 Internal h_cnt SHALL increment every clock and wrap from 799 to 0; v_cnt SHALL increment only on that wrap and wrap from 524 to 0.
REQ-020 Hcount and Vcount SHALL be the counter registers directly (zero latency); Vcount SHALL be v_cnt[8:0].
REQ-021 FrameStart SHALL be 1 exactly when h_cnt==0 && v_cnt==0, with no delay.
REQ-022 The raw visible flag SHALL be h_cnt<640 && v_cnt<480.
REQ-023 Raw Hsync SHALL be 0 for 656<=h_cnt<752 and 1 otherwise; raw Vsync SHALL be 0 for 490<=v_cnt<492 and 1 otherwise.
REQ-024 Raw Hsync, raw Vsync and the raw visible flag SHALL pass through a PIPE_DLY-stage shift, then one output register, so that Hsync, Vsync and Active lag the counts by PIPE_DLY+1 clocks.
REQ-025 Red_in, Green_in and Blue_in SHALL be sampled PIPE_DLY clocks after their count, then registered, so that they align with Active.
REQ-026 The registered colour SHALL be forced to 0 when the delayed visible flag is 0.
REQ-027 All boundary lengths SHALL derive from the parameters; sums SHALL be computed at 11-bit width so that no overflow occurs.

Reset
REQ-028 While Reset==0 at a rising Clk, h_cnt and v_cnt SHALL become 0.
REQ-029 While Reset==0 at a rising Clk, all delay stages SHALL be cleared to Hsync=1, Vsync=1, visible=0 and colour=0.
REQ-030 While Reset==0 at a rising Clk, the outputs SHALL be Hsync=1, Vsync=1, Active=0 and Red/Green/Blue=0.
REQ-031 FrameStart SHALL be held at 0 during reset.
REQ-032 On the first clock after reset release the counts SHALL be (0,0) and FrameStart SHALL be 1.
REQ-033 A reset asserted mid-frame SHALL abort the frame; timing SHALL restart at (0,0) with no partial sync pulse.

Structure
REQ-034 Timing defaults and the derived constants (H_TOTAL=800, V_TOTAL=525, sync start/end) SHALL live in a shared package, video_pkg.
REQ-035 The delay stages SHALL be one sub-module, delay_line, parameterized by width and depth and supporting depth 0.
REQ-036 The expected size SHALL be about 150-250 lines of RTL.

Verification
REQ-037 Scenario, reset release: hold Reset=0 for 5 clocks, release -> Hcount=0, Vcount=0, FrameStart=1 for 1 clock; Hsync=1, Vsync=1, Red=0.
REQ-038 Scenario, line wrap: run 800 clocks -> Hcount steps 799->0 and Vcount steps 0->1 on the same edge; FrameStart recurs only after 420000 clocks.
REQ-039 Scenario, horizontal sync: with PIPE_DLY=1, Hsync=0 for exactly 96 clocks, first low 2 clocks after Hcount==656.
REQ-040 Scenario, vertical sync: Vsync=0 for exactly 1600 clocks, starting 2 clocks after (0,490).
REQ-041 Scenario, colour gating: PIPE_DLY=2, Red_in=Hcount[7:0] -> at the cycle 3 clocks after Hcount=5 with v=0, Red=5 and Active=1; Red=0 throughout blanking and on lines 480-524.
REQ-042 Scenario, mid-frame reset: Reset=0 at (300,100) for 1 clock -> next clock all outputs are at reset values; after release counting restarts at (0,0) with FrameStart=1.
